// File: rtl/eth_frame_pkg.sv
// Shared types and constants for the eth FIFO read-side frame scheduler.
// Latency: n/a (declarations only). Backpressure: n/a.
package eth_frame_pkg;

   localparam int DATA_W          = 32;
   localparam int BYTES_PER_WORD  = 4;
   localparam int BYTE_SHIFT      = $clog2(BYTES_PER_WORD);
   localparam int TIMEOUT_CYC_DEF = 125000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      SEND      = 2'd2,
      WAIT_DONE = 2'd3
   } frame_state_t;

   // A zero-width counter is illegal, so a disabled timeout still gets one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/eth_flush_timer.sv
// Saturating partial-frame flush timer; expire is combinational on the final count.
// Latency: expire asserts in the cycle the count equals TIMEOUT_CYC-1. Backpressure: none; clr wins over en.
module eth_flush_timer
   import eth_frame_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int              CNT_W    = cnt_width(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
   localparam logic            TIMER_ON = (TIMEOUT_CYC != 0);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expire = TIMER_ON && en && (cnt == CNT_LAST);

endmodule

// File: rtl/eth_fifo_frame_ctrl.sv
// Launches UDP frames from the eth FIFO on full frame or flush timeout; optional stats via ETH_FRAME_CTRL_STATS_EN.
// Latency: tx_start_en one cycle after launch decision; fifo_rd_en combinational from tx_req. Backpressure: reads only on tx_req.
module eth_fifo_frame_ctrl
   import eth_frame_pkg::*;
#(
   parameter int DEPTH_W     = 10,
   parameter int DATA_W      = 32,
   parameter int LEN_W       = 16,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LEN_W-3:0]   cfg_frame_words,
   input  logic [DEPTH_W:0]   fifo_rd_water_level,
   input  logic               fifo_rd_empty,
   input  logic [DATA_W-1:0]  fifo_rd_data,
   output logic               fifo_rd_en,
   output logic               tx_start_en,
   output logic [LEN_W-1:0]   tx_byte_num,
   input  logic               tx_req,
   output logic [DATA_W-1:0]  tx_data,
   input  logic               tx_done,
   output logic               busy,
   output logic               underrun
`ifdef ETH_FRAME_CTRL_STATS_EN
   ,
   output logic [31:0]        stat_frames,
   output logic [15:0]        stat_short_frames,
   output logic [15:0]        stat_underruns
`endif
);

   localparam int LVL_W = DEPTH_W + 1;
   localparam int FW    = LEN_W - 2;
   localparam int CMP_W = (LVL_W > FW) ? LVL_W : FW;

   frame_state_t    state, state_nxt;
   logic [FW-1:0]   len;
   logic [FW-1:0]   words_left;
   logic [FW-1:0]   launch_len;
   logic [CMP_W-1:0] lvl_x, cfg_x;
   logic            cfg_zero, lvl_zero, full_rdy, part_rdy;
   logic            launch_full, timer_expire, launch;
   logic            word_step;

   // Compare at the wider of the two widths so an oversize frame length never aliases onto a small level.
   assign lvl_x    = CMP_W'(fifo_rd_water_level);
   assign cfg_x    = CMP_W'(cfg_frame_words);
   assign cfg_zero = (cfg_frame_words == '0);
   assign lvl_zero = (fifo_rd_water_level == '0);
   assign full_rdy = !cfg_zero && (lvl_x >= cfg_x);
   assign part_rdy = !cfg_zero && !lvl_zero && !full_rdy;

   assign launch_full = (state == IDLE) && full_rdy;
   assign launch      = launch_full || timer_expire;
   assign launch_len  = launch_full ? cfg_frame_words : FW'(lvl_x);

   eth_flush_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_flush_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    ((state != IDLE) || !part_rdy),
      .en     ((state == IDLE) && part_rdy),
      .expire (timer_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      word_step = 1'b0;
      case (state)
         IDLE: begin
            if (launch) state_nxt = START;
         end
         START: begin
            state_nxt = SEND;
         end
         SEND: begin
            // An empty-FIFO request still consumes a word slot so the frame length stays as announced.
            word_step = tx_req && (words_left != '0);
            if (tx_done) begin
               state_nxt = IDLE;
            end else if ((words_left == '0) || (word_step && (words_left == FW'(1)))) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len         <= '0;
         words_left  <= '0;
         tx_byte_num <= '0;
         underrun    <= 1'b0;
      end else begin
         if ((state == IDLE) && launch) begin
            len         <= launch_len;
            tx_byte_num <= LEN_W'(launch_len) << BYTE_SHIFT;
         end else if (((state == SEND) || (state == WAIT_DONE)) && tx_done) begin
            tx_byte_num <= '0;
         end
         if (state == START) begin
            words_left <= len;
         end else if (word_step) begin
            words_left <= words_left - FW'(1);
         end
         if (word_step && fifo_rd_empty) begin
            underrun <= 1'b1;
         end
      end
   end

   assign fifo_rd_en  = word_step && !fifo_rd_empty;
   assign tx_start_en = (state == START);
   assign busy        = (state != IDLE);
   assign tx_data     = fifo_rd_data;

`ifdef ETH_FRAME_CTRL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_frames       <= '0;
         stat_short_frames <= '0;
         stat_underruns    <= '0;
      end else begin
         if ((state == START) && (stat_frames != '1)) begin
            stat_frames <= stat_frames + 1'b1;
         end
         if ((state == IDLE) && timer_expire && (stat_short_frames != '1)) begin
            stat_short_frames <= stat_short_frames + 1'b1;
         end
         if (word_step && fifo_rd_empty && (stat_underruns != '1)) begin
            stat_underruns <= stat_underruns + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_eth_fifo_frame_ctrl.sv
// Directed bench for eth_fifo_frame_ctrl with a behavioural FIFO and a data scoreboard.
`timescale 1ns/1ps
module tb_eth_fifo_frame_ctrl;

   localparam int DEPTH_W = 10;
   localparam int DATA_W  = 32;
   localparam int LEN_W   = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst_n;
   logic [LEN_W-3:0]   cfg_frame_words;
   logic [DEPTH_W:0]   fifo_lvl;
   logic               model_empty, force_empty, fifo_rd_empty;
   logic [DATA_W-1:0]  fifo_rd_data;
   logic               fifo_rd_en, tx_start_en, tx_req, tx_done, busy, underrun;
   logic [LEN_W-1:0]   tx_byte_num;
   logic [DATA_W-1:0]  tx_data;
   logic               wr_vld;
   logic [DATA_W-1:0]  wr_dat;

   logic               nt_rd_en, nt_start, nt_busy, nt_underrun;
   logic [LEN_W-1:0]   nt_bytes;
   logic [DATA_W-1:0]  nt_data;

`ifdef ETH_FRAME_CTRL_STATS_EN
   logic [31:0] stat_frames, nt_stat_frames;
   logic [15:0] stat_short_frames, stat_underruns, nt_stat_short, nt_stat_under;
`endif

   logic [DATA_W-1:0] mem_q[$];
   logic [DATA_W-1:0] exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int rd_cnt = 0;
   int start_cnt = 0;
   int start_cyc = 0;
   int nt_start_cnt = 0;
   logic [LEN_W-1:0] last_bytes;

   assign fifo_rd_empty = model_empty | force_empty;

   eth_fifo_frame_ctrl #(
      .DEPTH_W(DEPTH_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .cfg_frame_words(cfg_frame_words),
      .fifo_rd_water_level(fifo_lvl), .fifo_rd_empty(fifo_rd_empty),
      .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
      .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_req(tx_req),
      .tx_data(tx_data), .tx_done(tx_done), .busy(busy), .underrun(underrun)
`ifdef ETH_FRAME_CTRL_STATS_EN
      , .stat_frames(stat_frames), .stat_short_frames(stat_short_frames),
      .stat_underruns(stat_underruns)
`endif
   );

   eth_fifo_frame_ctrl #(
      .DEPTH_W(DEPTH_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(0)
   ) dut_nt (
      .clk(clk), .rst_n(rst_n), .cfg_frame_words(14'd8),
      .fifo_rd_water_level(11'd3), .fifo_rd_empty(1'b0),
      .fifo_rd_data(32'h0), .fifo_rd_en(nt_rd_en),
      .tx_start_en(nt_start), .tx_byte_num(nt_bytes), .tx_req(1'b0),
      .tx_data(nt_data), .tx_done(1'b0), .busy(nt_busy), .underrun(nt_underrun)
`ifdef ETH_FRAME_CTRL_STATS_EN
      , .stat_frames(nt_stat_frames), .stat_short_frames(nt_stat_short),
      .stat_underruns(nt_stat_under)
`endif
   );

   // Behavioural synchronous FIFO: registered flags, read data one cycle after rd_en.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q.delete();
         fifo_lvl     <= '0;
         model_empty  <= 1'b1;
         fifo_rd_data <= '0;
      end else begin
         if (fifo_rd_en && (mem_q.size() > 0)) fifo_rd_data <= mem_q.pop_front();
         if (wr_vld) mem_q.push_back(wr_dat);
         fifo_lvl    <= (DEPTH_W+1)'(mem_q.size());
         model_empty <= (mem_q.size() == 0);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic        pre_rd;
      logic [31:0] exp;
      #1;
      pre_rd = fifo_rd_en;
      if (pre_rd) rd_cnt++;
      if (tx_start_en) begin
         start_cnt++;
         start_cyc  = cyc;
         last_bytes = tx_byte_num;
      end
      if (nt_start) nt_start_cnt++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (pre_rd) begin
         exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         check("tx_data", 64'(tx_data), 64'(exp));
      end
   endtask

   task automatic wr_word(input logic [31:0] d);
      wr_vld = 1'b1;
      wr_dat = d;
      exp_q.push_back(d);
      tick();
      wr_vld = 1'b0;
   endtask

   task automatic wait_start(input int budget);
      int s0;
      int n;
      s0 = start_cnt;
      n  = 0;
      while ((start_cnt == s0) && (n < budget)) begin
         tick();
         n++;
      end
      check("start_seen", 64'(start_cnt - s0), 64'd1);
   endtask

   task automatic req_burst(input int n);
      tx_req = 1'b1;
      repeat (n) tick();
      tx_req = 1'b0;
   endtask

   task automatic done_pulse();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   initial begin
      int r0;
      int s0;
      int lvl_cyc;
      rst_n = 1'b0; cfg_frame_words = '0; force_empty = 1'b0;
      tx_req = 1'b0; tx_done = 1'b0; wr_vld = 1'b0; wr_dat = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_start", 64'(tx_start_en), 64'd0);
      check("rst_bytes", 64'(tx_byte_num), 64'd0);
      check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
      check("rst_underrun", 64'(underrun), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Full 8-word frame
      cfg_frame_words = 14'd8;
      for (int i = 1; i <= 8; i++) wr_word(32'(i));
      wait_start(10);
      check("s1_bytes", 64'(last_bytes), 64'd32);
      check("s1_pulse_1cyc", 64'(tx_start_en), 64'd0);
      r0 = rd_cnt;
      req_burst(8);
      check("s1_reads", 64'(rd_cnt - r0), 64'd8);
      repeat (2) tick();
      check("s1_busy_wait", 64'(busy), 64'd1);
      check("s1_bytes_held", 64'(tx_byte_num), 64'd32);
      done_pulse();
      check("s1_busy_after_done", 64'(busy), 64'd0);
      check("s1_bytes_clr", 64'(tx_byte_num), 64'd0);

      // Partial frame flushed by timeout
      wr_word(32'h11);
      lvl_cyc = cyc;
      check("s2_level", 64'(fifo_lvl), 64'd1);
      wr_word(32'h12);
      wr_word(32'h13);
      wait_start(150);
      check("s2_latency", 64'(start_cyc - lvl_cyc), 64'd100);
      check("s2_bytes", 64'(last_bytes), 64'd12);
      r0 = rd_cnt;
      req_burst(3);
      check("s2_reads", 64'(rd_cnt - r0), 64'd3);
      done_pulse();

      // Excess tx_req beyond frame length
      cfg_frame_words = 14'd4;
      for (int i = 0; i < 4; i++) wr_word(32'h21 + 32'(i));
      wait_start(10);
      check("s4_bytes", 64'(last_bytes), 64'd16);
      r0 = rd_cnt;
      req_burst(6);
      check("s4_reads", 64'(rd_cnt - r0), 64'd4);
      check("s4_level", 64'(fifo_lvl), 64'd0);
      check("s4_underrun", 64'(underrun), 64'd0);
      done_pulse();
      check("s4_busy", 64'(busy), 64'd0);

      // Underrun: only 2 of 4 words readable
      for (int i = 0; i < 4; i++) wr_word(32'h31 + 32'(i));
      wait_start(10);
      req_burst(2);
      force_empty = 1'b1;
      r0 = rd_cnt;
      req_burst(2);
      check("s5_no_read_empty", 64'(rd_cnt - r0), 64'd0);
      check("s5_level_kept", 64'(fifo_lvl), 64'd2);
      check("s5_underrun", 64'(underrun), 64'd1);
      check("s5_wait_done", 64'(dut.state), 64'd3);
      tick();
      check("s5_underrun_sticky", 64'(underrun), 64'd1);
      tx_done = 1'b1; force_empty = 1'b0; cfg_frame_words = 14'd2;
      tick();
      tx_done = 1'b0;
      wait_start(10);
      check("s5_bytes_rest", 64'(last_bytes), 64'd8);
      req_burst(2);
      done_pulse();
      check("s5_sb_drained", 64'(exp_q.size()), 64'd0);
      check("s5_underrun_still", 64'(underrun), 64'd1);

      // Reset mid-SEND, then disabled config with data queued
      cfg_frame_words = 14'd4;
      for (int i = 0; i < 4; i++) wr_word(32'h41 + 32'(i));
      wait_start(10);
      tx_req = 1'b1;
      tick();
      check("s6_in_send", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_busy", 64'(busy), 64'd0);
      check("s6_rd_en", 64'(fifo_rd_en), 64'd0);
      check("s6_start", 64'(tx_start_en), 64'd0);
      check("s6_bytes", 64'(tx_byte_num), 64'd0);
      check("s6_underrun", 64'(underrun), 64'd0);
      check("s6_tx_data", 64'(tx_data), 64'd0);
      check("s6_state", 64'(dut.state), 64'd0);
      exp_q.delete();
      tx_req = 1'b0;
      cfg_frame_words = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      s0 = start_cnt;
      for (int i = 0; i < 5; i++) wr_word(32'h51 + 32'(i));
      repeat (300) tick();
      check("s6_no_frame", 64'(start_cnt - s0), 64'd0);
      check("s6_idle", 64'(busy), 64'd0);
      check("s6_level", 64'(fifo_lvl), 64'd5);

      // Timeout disabled instance: partial frame never launches
      repeat (10000) tick();
      check("s3_no_start", 64'(nt_start_cnt), 64'd0);
      check("s3_idle", 64'(nt_busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
